// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Definitions shared by the BNN layer sequencer and the array top.
//   state_e    : one-hot sequencer states, S_IDLE..S_DONE
//   WADDR_CONV : weight-set index holding the convolution weights
//   MODE_*     : array mux select encoding (0 conv / 1 FC), shared with the
//                array so both sides agree on the meaning of 'mode'
//   calc_nwin  : number of KxK window positions along one image axis
// ---------------------------------------------------------------------------
package bnn_pkg;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_CW_LD = 6'b000010,
        S_CONV  = 6'b000100,
        S_FW_LD = 6'b001000,
        S_FC    = 6'b010000,
        S_DONE  = 6'b100000
    } state_e;

    localparam int   WADDR_CONV = 0;
    localparam logic MODE_CONV  = 1'b0;
    localparam logic MODE_FC    = 1'b1;

    function automatic int calc_nwin(input int imgW, input int k);
        return imgW - k + 1;
    endfunction

endpackage

// File: rtl/bnn_win_cnt.sv
// ---------------------------------------------------------------------------
// bnn_win_cnt
// Two-dimensional raster counter over an NWIN x NWIN grid of positions.
// Column advances on every enable; when it passes the last column it returns
// to 0 and the row advances. Leaving the last position wraps both to 0, so
// the counter is already cleared for the next pass without an extra cycle.
// Also usable by the line buffer to track its write position.
// Ports:
//   clk     in   rising-edge clock
//   rstn    in   asynchronous active-low reset
//   en_i    in   advance one position
//   clr_i   in   synchronous clear to (0,0); has priority over en_i
//   row_o   out  current row
//   col_o   out  current column
//   last_o  out  current position is the final one (NWIN-1, NWIN-1)
// ---------------------------------------------------------------------------
module bnn_win_cnt
    import bnn_pkg::*;
#(
    parameter int NWIN  = 9,
    parameter int CRD_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CRD_W-1:0] row_o,
    output logic [CRD_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [CRD_W-1:0] LAST_CRD = CRD_W'(NWIN - 1);

    logic [CRD_W-1:0] row_q, row_d;
    logic [CRD_W-1:0] col_q, col_d;
    logic             rowLast;
    logic             colLast;

    // Comparisons are against the last grid position, never the counter
    // width, so the grid size need not be a power of two.
    assign rowLast = (row_q == LAST_CRD);
    assign colLast = (col_q == LAST_CRD);

    // Next position in raster order.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (colLast) begin
                col_d = '0;
                row_d = rowLast ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = rowLast & colLast;

endmodule

// File: rtl/bnn_layer_sched.sv
// ---------------------------------------------------------------------------
// bnn_layer_sched
// Layer sequencer for the shared BNN conv/FC array. On a start request it
// fetches the convolution weights, walks every KxK window of the IMG_W x IMG_W
// map in raster order, then runs FC_OUT fully-connected passes, each preceded
// by its own weight fetch, and finally pulses done for one cycle.
// Ports:
//   clk         in   rising-edge clock
//   rstn        in   asynchronous active-low reset (aborts a running layer)
//   start       in   start request, honoured only while idle
//   win_rdy     in   line buffer has window data; transfer = conv_valid & win_rdy
//   w_gnt       in   weight memory has data for w_addr; completes w_req
//   w_req       out  weight fetch request, held until granted
//   w_addr      out  weight set index: 0 conv, 1+i FC pass i
//   w_load      out  capture strobe for the array weight registers
//   mode        out  array mux select, 0 conv / 1 FC
//   conv_valid  out  window coordinate is valid
//   win_row     out  window top-left row
//   win_col     out  window top-left column
//   fc_valid    out  FC pass fc_idx computed this cycle
//   fc_idx      out  current FC pass index
//   busy        out  high whenever not idle
//   done        out  one-cycle pulse on the final cycle of the layer
// ---------------------------------------------------------------------------
module bnn_layer_sched
    import bnn_pkg::*;
#(
    parameter int IMG_W   = 12,
    parameter int K       = 4,
    parameter int FC_OUT  = 10,
    parameter int CRD_W   = 4,
    parameter int WADDR_W = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               win_rdy,
    input  logic               w_gnt,
    output logic               w_req,
    output logic [WADDR_W-1:0] w_addr,
    output logic               w_load,
    output logic               mode,
    output logic               conv_valid,
    output logic [CRD_W-1:0]   win_row,
    output logic [CRD_W-1:0]   win_col,
    output logic               fc_valid,
    output logic [3:0]         fc_idx,
    output logic               busy,
    output logic               done
);

    localparam int         NWIN    = calc_nwin(IMG_W, K);
    localparam logic [3:0] FC_LAST = 4'(FC_OUT - 1);

    state_e     state_q, state_d;
    logic [3:0] fcIdx_q, fcIdx_d;
    logic       convXfer;
    logic       winLast;
    logic       cntClr;

    // A window is consumed only when the line buffer accepts it; while
    // win_rdy is low the coordinates stay put.
    assign convXfer = conv_valid & win_rdy;
    assign cntClr   = (state_q == S_IDLE);

    bnn_win_cnt #(
        .NWIN  (NWIN),
        .CRD_W (CRD_W)
    ) u_win_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (convXfer),
        .clr_i  (cntClr),
        .row_o  (win_row),
        .col_o  (win_col),
        .last_o (winLast)
    );

    // Next-state and output decode. All outputs except w_load depend only
    // on registered state, so win_rdy never reaches an output directly.
    always_comb begin
        state_d    = state_q;
        fcIdx_d    = fcIdx_q;
        w_req      = 1'b0;
        w_addr     = '0;
        mode       = MODE_CONV;
        conv_valid = 1'b0;
        fc_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_CW_LD;
                end
            end
            S_CW_LD: begin
                w_req  = 1'b1;
                w_addr = WADDR_W'(WADDR_CONV);
                if (w_gnt) begin
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                conv_valid = 1'b1;
                // The counter wraps to (0,0) on the final transfer, leaving
                // it clear for the next layer.
                if (win_rdy && winLast) begin
                    state_d = S_FW_LD;
                end
            end
            S_FW_LD: begin
                mode   = MODE_FC;
                w_req  = 1'b1;
                w_addr = WADDR_W'(fcIdx_q) + WADDR_W'(1);
                if (w_gnt) begin
                    state_d = S_FC;
                end
            end
            S_FC: begin
                mode     = MODE_FC;
                fc_valid = 1'b1;
                if (fcIdx_q == FC_LAST) begin
                    fcIdx_d = '0;
                    state_d = S_DONE;
                end else begin
                    fcIdx_d = fcIdx_q + 1'b1;
                    state_d = S_FW_LD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
                fcIdx_d = '0;
            end
        endcase
    end

    // Grant completes a fetch in the same cycle it is seen.
    assign w_load = w_req & w_gnt;
    assign fc_idx = fcIdx_q;

    // State and FC pass registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            fcIdx_q <= '0;
        end else begin
            state_q <= state_d;
            fcIdx_q <= fcIdx_d;
        end
    end

endmodule

// File: tb/tb_bnn_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_bnn_layer_sched
// Directed bench for bnn_layer_sched: a default-size instance (12/4/10) and
// a small instance (6/3/2) are driven with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_bnn_layer_sched;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       winRdy = 1'b1;
    logic       wGnt = 1'b0;

    logic       wReq, wLoad, mode, convValid, fcValid, busy, done;
    logic [4:0] wAddr;
    logic [3:0] winRow, winCol, fcIdx;

    logic       startS = 1'b0;
    logic       winRdyS = 1'b1;
    logic       wGntS = 1'b1;
    logic       wReqS, wLoadS, modeS, convValidS, fcValidS, busyS, doneS;
    logic [1:0] wAddrS;
    logic [1:0] winRowS, winColS;
    logic [3:0] fcIdxS;

    int total = 0;
    int bad = 0;

    // Clock generation.
    always #5 clk = ~clk;

    bnn_layer_sched #(
        .IMG_W(12), .K(4), .FC_OUT(10), .CRD_W(4), .WADDR_W(5)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .win_rdy(winRdy), .w_gnt(wGnt),
        .w_req(wReq), .w_addr(wAddr), .w_load(wLoad), .mode(mode),
        .conv_valid(convValid), .win_row(winRow), .win_col(winCol),
        .fc_valid(fcValid), .fc_idx(fcIdx), .busy(busy), .done(done)
    );

    bnn_layer_sched #(
        .IMG_W(6), .K(3), .FC_OUT(2), .CRD_W(2), .WADDR_W(2)
    ) dutSmall (
        .clk(clk), .rstn(rstn), .start(startS), .win_rdy(winRdyS), .w_gnt(wGntS),
        .w_req(wReqS), .w_addr(wAddrS), .w_load(wLoadS), .mode(modeS),
        .conv_valid(convValidS), .win_row(winRowS), .win_col(winColS),
        .fc_valid(fcValidS), .fc_idx(fcIdxS), .busy(busyS), .done(doneS)
    );

    // Event logs for the default instance, sampled on the falling edge.
    int rowLog[$], colLog[$], fcLog[$], addrLog[$];
    int doneCnt, busyCycles, overlap, reqBreak, stallBreak, stallCycles, modeBreak;
    logic prevReq, prevLoad, prevStall;
    logic [4:0] prevAddr;
    logic [3:0] prevRow, prevCol;

    always @(negedge clk) begin
        if (convValid && winRdy) begin
            rowLog.push_back(int'(winRow));
            colLog.push_back(int'(winCol));
        end
        if (fcValid) fcLog.push_back(int'(fcIdx));
        if (wLoad) addrLog.push_back(int'(wAddr));
        if (done) doneCnt++;
        if (busy) busyCycles++;
        if (convValid && fcValid) overlap++;
        if ((convValid && mode) || (fcValid && !mode)) modeBreak++;
        if (wReq && ((wAddr == 5'd0) == mode)) modeBreak++;
        if (prevReq && !prevLoad && (!wReq || wAddr != prevAddr)) reqBreak++;
        if (prevStall && (!convValid || winRow != prevRow || winCol != prevCol)) stallBreak++;
        if (convValid && !winRdy) stallCycles++;
        prevReq   = wReq;
        prevLoad  = wLoad;
        prevAddr  = wAddr;
        prevStall = convValid && !winRdy;
        prevRow   = winRow;
        prevCol   = winCol;
    end

    // Event logs for the small instance.
    int rowLogS[$], colLogS[$], fcLogS[$], addrLogS[$];
    int doneCntS, busyCyclesS, modeBreakS;

    always @(negedge clk) begin
        if (convValidS && winRdyS) begin
            rowLogS.push_back(int'(winRowS));
            colLogS.push_back(int'(winColS));
        end
        if (fcValidS) fcLogS.push_back(int'(fcIdxS));
        if (wLoadS) addrLogS.push_back(int'(wAddrS));
        if (doneS) doneCntS++;
        if (busyS) busyCyclesS++;
        if ((convValidS && modeS) || (fcValidS && !modeS)) modeBreakS++;
    end

    task automatic clearLogs();
        rowLog.delete(); colLog.delete(); fcLog.delete(); addrLog.delete();
        doneCnt = 0; busyCycles = 0; overlap = 0; reqBreak = 0;
        stallBreak = 0; stallCycles = 0; modeBreak = 0;
        prevReq = 1'b0; prevLoad = 1'b0; prevStall = 1'b0;
        prevAddr = '0; prevRow = '0; prevCol = '0;
        rowLogS.delete(); colLogS.delete(); fcLogS.delete(); addrLogS.delete();
        doneCntS = 0; busyCyclesS = 0; modeBreakS = 0;
    endtask

    // Runs one layer on the default instance. stallLen holds win_rdy low at
    // window (3,7); gntDelay withholds each grant that many cycles (0 = tied
    // high); pokeStart raises start at window (2,2) and in DONE. Returns the
    // cycle count from the start cycle to the done cycle inclusive, or the
    // budget if done never arrives. Ends one cycle after done, start low.
    task automatic applyStimulus(input int budget, input int stallLen, input int gntDelay,
                                 input bit pokeStart, output int cycles);
        int stallLeft;
        int gntWait;
        stallLeft = stallLen;
        gntWait = 0;
        @(posedge clk); #1;
        start = 1'b1; winRdy = 1'b1; wGnt = (gntDelay == 0);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done) break;
            @(posedge clk); #1;
            start = 1'b0;
            if (stallLeft > 0 && convValid && winRow == 4'd3 && winCol == 4'd7) begin
                winRdy = 1'b0;
                stallLeft--;
            end else begin
                winRdy = 1'b1;
            end
            if (gntDelay == 0) begin
                wGnt = 1'b1;
            end else if (wReq) begin
                if (gntWait >= gntDelay) begin
                    wGnt = 1'b1;
                    gntWait = 0;
                end else begin
                    wGnt = 1'b0;
                    gntWait++;
                end
            end else begin
                wGnt = 1'b0;
                gntWait = 0;
            end
            if (pokeStart && ((convValid && winRow == 4'd2 && winCol == 4'd2) || done)) start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; winRdy = 1'b1; wGnt = 1'b1;
        #12;
        total++;
        if ({wReq, wLoad, mode, convValid, fcValid, busy, done, wAddr, winRow, winCol, fcIdx} !== 24'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {wReq, wLoad, mode, convValid, fcValid, busy, done, wAddr, winRow, winCol, fcIdx});
        end
        total++;
        if ({wReqS, wLoadS, modeS, convValidS, fcValidS, busyS, doneS, wAddrS, winRowS, winColS, fcIdxS} !== 17'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs_small: got %h expected 0",
                     {wReqS, wLoadS, modeS, convValidS, fcValidS, busyS, doneS, wAddrS, winRowS, winColS, fcIdxS});
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, wReq, wLoad} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL idle_without_start: got %b expected 000", {busy, wReq, wLoad});
        end
    endtask

    task automatic test_full_layer();
        int cycles;
        int errs;
        clearLogs();
        applyStimulus(300, 0, 0, 1'b0, cycles);
        total++;
        if (cycles !== 104) begin
            bad++; $display("[TB] FAIL full_cycles: got %0d expected 104", cycles);
        end
        total++;
        if (rowLog.size() !== 81) begin
            bad++; $display("[TB] FAIL full_transfers: got %0d expected 81", rowLog.size());
        end
        errs = 0;
        foreach (rowLog[i]) if (rowLog[i] !== i / 9 || colLog[i] !== i % 9) errs++;
        total++;
        if (errs !== 0) begin
            bad++; $display("[TB] FAIL full_raster: got %0d wrong coordinates expected 0", errs);
        end
        errs = 0;
        foreach (fcLog[i]) if (fcLog[i] !== i) errs++;
        total++;
        if (fcLog.size() !== 10 || errs !== 0) begin
            bad++; $display("[TB] FAIL full_fc_seq: got %0d strobes %0d wrong expected 10 strobes 0 wrong", fcLog.size(), errs);
        end
        errs = 0;
        foreach (addrLog[i]) if (addrLog[i] !== i) errs++;
        total++;
        if (addrLog.size() !== 11 || errs !== 0) begin
            bad++; $display("[TB] FAIL full_addr_seq: got %0d loads %0d wrong expected 11 loads 0 wrong", addrLog.size(), errs);
        end
        total++;
        if (doneCnt !== 1) begin
            bad++; $display("[TB] FAIL full_done: got %0d expected 1", doneCnt);
        end
        total++;
        if (busyCycles !== 103) begin
            bad++; $display("[TB] FAIL full_busy: got %0d expected 103", busyCycles);
        end
        total++;
        if (overlap !== 0 || modeBreak !== 0) begin
            bad++; $display("[TB] FAIL full_mode: got overlap=%0d modeBreak=%0d expected 0 0", overlap, modeBreak);
        end
    endtask

    task automatic test_win_stall();
        int cycles;
        int errs;
        clearLogs();
        applyStimulus(300, 5, 0, 1'b0, cycles);
        total++;
        if (cycles !== 109) begin
            bad++; $display("[TB] FAIL stall_cycles: got %0d expected 109", cycles);
        end
        errs = 0;
        foreach (rowLog[i]) if (rowLog[i] !== i / 9 || colLog[i] !== i % 9) errs++;
        total++;
        if (rowLog.size() !== 81 || errs !== 0) begin
            bad++; $display("[TB] FAIL stall_transfers: got %0d transfers %0d wrong expected 81 0", rowLog.size(), errs);
        end
        total++;
        if (stallCycles !== 5) begin
            bad++; $display("[TB] FAIL stall_len: got %0d expected 5", stallCycles);
        end
        total++;
        if (stallBreak !== 0) begin
            bad++; $display("[TB] FAIL stall_hold: got %0d moves expected 0", stallBreak);
        end
    endtask

    task automatic test_grant_delay();
        int cycles;
        int errs;
        clearLogs();
        applyStimulus(400, 0, 3, 1'b0, cycles);
        total++;
        if (cycles !== 137) begin
            bad++; $display("[TB] FAIL gnt_cycles: got %0d expected 137", cycles);
        end
        errs = 0;
        foreach (addrLog[i]) if (addrLog[i] !== i) errs++;
        total++;
        if (addrLog.size() !== 11 || errs !== 0) begin
            bad++; $display("[TB] FAIL gnt_loads: got %0d loads %0d wrong expected 11 0", addrLog.size(), errs);
        end
        total++;
        if (reqBreak !== 0) begin
            bad++; $display("[TB] FAIL gnt_req_stable: got %0d breaks expected 0", reqBreak);
        end
        total++;
        if (fcLog.size() !== 10 || modeBreak !== 0) begin
            bad++; $display("[TB] FAIL gnt_fc: got %0d strobes modeBreak=%0d expected 10 0", fcLog.size(), modeBreak);
        end
    endtask

    task automatic test_start_ignored();
        int cycles;
        clearLogs();
        applyStimulus(300, 0, 0, 1'b1, cycles);
        repeat (4) @(negedge clk);
        total++;
        if (cycles !== 104) begin
            bad++; $display("[TB] FAIL poke_cycles: got %0d expected 104", cycles);
        end
        total++;
        if (doneCnt !== 1) begin
            bad++; $display("[TB] FAIL poke_done: got %0d expected 1", doneCnt);
        end
        total++;
        if (busy !== 1'b0 || busyCycles !== 103) begin
            bad++; $display("[TB] FAIL poke_idle: got busy=%b busyCycles=%0d expected 0 103", busy, busyCycles);
        end
        total++;
        if (rowLog.size() !== 81) begin
            bad++; $display("[TB] FAIL poke_transfers: got %0d expected 81", rowLog.size());
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        int errs;
        bit found;
        found = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; winRdy = 1'b1; wGnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (fcValid && fcIdx == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (found !== 1'b1) begin
            bad++; $display("[TB] FAIL rst_reach_fc4: got %b expected 1", found);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({wReq, wLoad, mode, convValid, fcValid, busy, done, wAddr, winRow, winCol, fcIdx} !== 24'd0) begin
            bad++;
            $display("[TB] FAIL rst_async_clear: got %h expected 0",
                     {wReq, wLoad, mode, convValid, fcValid, busy, done, wAddr, winRow, winCol, fcIdx});
        end
        @(negedge clk);
        rstn = 1'b1;
        clearLogs();
        applyStimulus(300, 0, 0, 1'b0, cycles);
        total++;
        if (cycles !== 104) begin
            bad++; $display("[TB] FAIL rst_rerun_cycles: got %0d expected 104", cycles);
        end
        errs = 0;
        foreach (fcLog[i]) if (fcLog[i] !== i) errs++;
        total++;
        if (fcLog.size() !== 10 || errs !== 0) begin
            bad++; $display("[TB] FAIL rst_rerun_fc: got %0d strobes %0d wrong expected 10 0", fcLog.size(), errs);
        end
        errs = 0;
        foreach (rowLog[i]) if (rowLog[i] !== i / 9 || colLog[i] !== i % 9) errs++;
        total++;
        if (rowLog.size() !== 81 || errs !== 0 || doneCnt !== 1) begin
            bad++; $display("[TB] FAIL rst_rerun_conv: got %0d transfers %0d wrong %0d done expected 81 0 1",
                            rowLog.size(), errs, doneCnt);
        end
    endtask

    task automatic test_small_config();
        int cycles;
        int errs;
        clearLogs();
        @(posedge clk); #1;
        startS = 1'b1;
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (doneS) break;
            @(posedge clk); #1;
            startS = 1'b0;
        end
        @(posedge clk); #1;
        startS = 1'b0;
        total++;
        if (cycles !== 23) begin
            bad++; $display("[TB] FAIL small_cycles: got %0d expected 23", cycles);
        end
        errs = 0;
        foreach (rowLogS[i]) if (rowLogS[i] !== i / 4 || colLogS[i] !== i % 4) errs++;
        total++;
        if (rowLogS.size() !== 16 || errs !== 0) begin
            bad++; $display("[TB] FAIL small_windows: got %0d transfers %0d wrong expected 16 0", rowLogS.size(), errs);
        end
        total++;
        if (rowLogS.size() == 0 || rowLogS[rowLogS.size()-1] !== 3 || colLogS[colLogS.size()-1] !== 3) begin
            bad++; $display("[TB] FAIL small_last_window: got %0d transfers expected last (3,3)", rowLogS.size());
        end
        errs = 0;
        foreach (addrLogS[i]) if (addrLogS[i] !== i) errs++;
        foreach (fcLogS[i]) if (fcLogS[i] !== i) errs++;
        total++;
        if (addrLogS.size() !== 3 || fcLogS.size() !== 2 || errs !== 0) begin
            bad++; $display("[TB] FAIL small_fc_addr: got %0d loads %0d strobes %0d wrong expected 3 2 0",
                            addrLogS.size(), fcLogS.size(), errs);
        end
        total++;
        if (doneCntS !== 1 || busyCyclesS !== 22 || modeBreakS !== 0) begin
            bad++; $display("[TB] FAIL small_done_busy: got done=%0d busy=%0d modeBreak=%0d expected 1 22 0",
                            doneCntS, busyCyclesS, modeBreakS);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        clearLogs();
        test_reset();
        test_full_layer();
        test_win_stall();
        test_grant_delay();
        test_start_ignored();
        test_reset_mid();
        test_small_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
